// File: rtl/spmv_mem_arbiter.sv
// Fixed-priority arbiter (mac store > cache load > decoder load) feeding a registered memory port through a skid FIFO.
// Define SPMV_ARB_STARVE_GUARD_EN to add a starvation guard that forces a decoder grant after STARVE_LIMIT lost cycles.
module spmv_mem_arbiter #(
    parameter int SKID_DEPTH   = 4,
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        st_base_ld,
    input  logic [47:0] st_base,
    input  logic [47:0] st_end,
    input  logic        mac_valid,
    input  logic [63:0] mac_data,
    output logic        mac_ready,
    input  logic        cache_valid,
    input  logic [47:0] cache_addr,
    output logic        cache_ready,
    input  logic        dec_valid,
    input  logic [47:0] dec_addr,
    input  logic [1:0]  dec_tag,
    output logic        dec_ready,
    output logic        req_mem_ld,
    output logic        req_mem_st,
    output logic [47:0] req_mem_addr,
    output logic [63:0] req_mem_d_or_tag,
    input  logic        req_mem_stall,
    output logic [47:0] st_addr,
    output logic        idle
);
    localparam int PTR_W = $clog2(SKID_DEPTH);

    typedef struct packed {
        logic [63:0] d_or_tag;
        logic [47:0] addr;
        logic        st;
        logic        ld;
    } entry_t;

    entry_t           fifo_mem [SKID_DEPTH];
    entry_t           push_entry;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q, count_d;
    logic [47:0]      st_addr_q, st_addr_d;
    logic             stall_q;
    logic             req_ld_q, req_st_q;
    logic [47:0]      req_addr_q;
    logic [63:0]      req_data_q;

    logic fifo_full, fifo_empty, can_grant, dec_force;
    logic mac_acc, cache_acc, dec_acc, st_drop, push, pop;

    assign fifo_full  = (count_q == (PTR_W+1)'(SKID_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign can_grant  = rst && !fifo_full;

`ifdef SPMV_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    logic [CNT_W-1:0] starve_q, starve_d;

    assign dec_force = dec_valid && (starve_q >= CNT_W'(STARVE_LIMIT));

    always_comb begin
        starve_d = starve_q;
        if (!dec_valid || dec_acc) begin
            starve_d = '0;
        end else if (starve_q < CNT_W'(STARVE_LIMIT)) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // STARVE_LIMIT is always positive, so this folds to a constant 0.
    assign dec_force = dec_valid && (STARVE_LIMIT < 0);
`endif

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        mac_ready   = 1'b0;
        cache_ready = 1'b0;
        dec_ready   = 1'b0;
        if (can_grant) begin
            if (dec_force) begin
                dec_ready = 1'b1;
            end else if (mac_valid) begin
                mac_ready = 1'b1;
            end else if (cache_valid) begin
                cache_ready = 1'b1;
            end else if (dec_valid) begin
                dec_ready = 1'b1;
            end
        end
    end

    assign mac_acc   = mac_valid && mac_ready;
    assign cache_acc = cache_valid && cache_ready;
    assign dec_acc   = dec_valid && dec_ready;
    assign st_drop   = (st_addr_q == st_end);
    assign push      = (mac_acc && !st_drop) || cache_acc || dec_acc;
    assign pop       = !fifo_empty && !stall_q;

    always_comb begin
        push_entry = '0;
        if (mac_acc) begin
            push_entry = '{d_or_tag: mac_data, addr: st_addr_q, st: 1'b1, ld: 1'b0};
        end else if (cache_acc) begin
            push_entry = '{d_or_tag: 64'h1, addr: cache_addr, st: 1'b0, ld: 1'b1};
        end else if (dec_acc) begin
            push_entry = '{d_or_tag: {61'b0, dec_tag, 1'b0}, addr: dec_addr, st: 1'b0, ld: 1'b1};
        end
    end

    // A concurrent base load wins over the post-store increment.
    always_comb begin
        st_addr_d = st_addr_q;
        if (st_base_ld) begin
            st_addr_d = st_base;
        end else if (mac_acc && !st_drop) begin
            st_addr_d = st_addr_q + 48'd8;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: FIFO storage is not reset; emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            st_addr_q  <= '0;
            stall_q    <= 1'b1;
            req_ld_q   <= 1'b0;
            req_st_q   <= 1'b0;
            req_addr_q <= '0;
            req_data_q <= '0;
        end else begin
            count_q   <= count_d;
            st_addr_q <= st_addr_d;
            stall_q   <= req_mem_stall;
            req_ld_q  <= pop && fifo_mem[rd_ptr_q].ld;
            req_st_q  <= pop && fifo_mem[rd_ptr_q].st;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                req_addr_q <= fifo_mem[rd_ptr_q].addr;
                req_data_q <= fifo_mem[rd_ptr_q].d_or_tag;
            end
        end
    end

    assign req_mem_ld       = req_ld_q;
    assign req_mem_st       = req_st_q;
    assign req_mem_addr     = req_addr_q;
    assign req_mem_d_or_tag = req_data_q;
    assign st_addr          = st_addr_q;
    assign idle             = fifo_empty && !mac_valid && !cache_valid && !dec_valid
                              && !req_ld_q && !req_st_q;
endmodule

// File: tb/tb_spmv_mem_arbiter.sv
// Directed testbench for spmv_mem_arbiter: stores with end-of-range drop, priority order,
// skid backpressure, mid-stream reset and decoder starvation behaviour (guarded or not).
module tb_spmv_mem_arbiter;
    localparam int SKID_DEPTH   = 4;
    localparam int STARVE_LIMIT = 4;
`ifdef SPMV_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    localparam logic [63:0] F1_0 = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] F2_0 = 64'h4000_0000_0000_0000;
    localparam logic [63:0] F3_0 = 64'h4008_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        st_base_ld;
    logic [47:0] st_base, st_end;
    logic        mac_valid, mac_ready;
    logic [63:0] mac_data;
    logic        cache_valid, cache_ready;
    logic [47:0] cache_addr;
    logic        dec_valid, dec_ready;
    logic [47:0] dec_addr;
    logic [1:0]  dec_tag;
    logic        req_mem_ld, req_mem_st, req_mem_stall;
    logic [47:0] req_mem_addr;
    logic [63:0] req_mem_d_or_tag;
    logic [47:0] st_addr;
    logic        idle;

    int n_assert = 0;
    int n_fail   = 0;

    spmv_mem_arbiter #(
        .SKID_DEPTH  (SKID_DEPTH),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .st_base_ld      (st_base_ld),
        .st_base         (st_base),
        .st_end          (st_end),
        .mac_valid       (mac_valid),
        .mac_data        (mac_data),
        .mac_ready       (mac_ready),
        .cache_valid     (cache_valid),
        .cache_addr      (cache_addr),
        .cache_ready     (cache_ready),
        .dec_valid       (dec_valid),
        .dec_addr        (dec_addr),
        .dec_tag         (dec_tag),
        .dec_ready       (dec_ready),
        .req_mem_ld      (req_mem_ld),
        .req_mem_st      (req_mem_st),
        .req_mem_addr    (req_mem_addr),
        .req_mem_d_or_tag(req_mem_d_or_tag),
        .req_mem_stall   (req_mem_stall),
        .st_addr         (st_addr),
        .idle            (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc;
        int          n_got;
        logic [47:0] got [8];
        bit          exp_dec;

        // Reset: outputs and readies low even with every requester valid.
        rst = 1'b0; st_base_ld = 1'b0; st_base = '0; st_end = '0;
        mac_valid = 1'b1; mac_data = '0; cache_valid = 1'b1; cache_addr = '0;
        dec_valid = 1'b1; dec_addr = '0; dec_tag = '0; req_mem_stall = 1'b0;
        #2;
        check("rst_mac_ready", mac_ready, 0);
        check("rst_cache_ready", cache_ready, 0);
        check("rst_dec_ready", dec_ready, 0);
        check("rst_ld", req_mem_ld, 0);
        check("rst_st", req_mem_st, 0);
        check("rst_addr", req_mem_addr, 0);
        check("rst_data", req_mem_d_or_tag, 0);
        check("rst_st_addr", st_addr, 0);
        mac_valid = 1'b0; cache_valid = 1'b0; dec_valid = 1'b0;
        #1 check("rst_idle", idle, 1);

        // Store window 0x1000..0x1010: two stores issue, the third is acked and dropped.
        next();
        rst = 1'b1; st_base_ld = 1'b1; st_base = 48'h1000; st_end = 48'h1010;
        next();
        st_base_ld = 1'b0;
        check("base_load", st_addr, 48'h1000);
        mac_valid = 1'b1; mac_data = F1_0;
        #1 check("mac1_ready", mac_ready, 1);
        next();
        check("st_addr_1008", st_addr, 48'h1008);
        mac_data = F2_0;
        #1 check("mac2_ready", mac_ready, 1);
        next();
        check("store1_st", req_mem_st, 1);
        check("store1_addr", req_mem_addr, 48'h1000);
        check("store1_data", req_mem_d_or_tag, F1_0);
        check("st_addr_1010", st_addr, 48'h1010);
        mac_data = F3_0;
        #1 check("mac3_ready_drop", mac_ready, 1);
        next();
        check("store2_st", req_mem_st, 1);
        check("store2_addr", req_mem_addr, 48'h1008);
        check("store2_data", req_mem_d_or_tag, F2_0);
        check("st_addr_hold", st_addr, 48'h1010);
        mac_valid = 1'b0;
        next();
        check("drop_no_st", req_mem_st, 0);
        check("drop_no_ld", req_mem_ld, 0);
        check("drop_idle", idle, 1);

        // All three valid together: st, cache ld, dec ld, first issue at N+2.
        st_base_ld = 1'b1; st_base = 48'h2000; st_end = 48'h3000;
        next();
        st_base_ld = 1'b0;
        check("base_2000", st_addr, 48'h2000);
        mac_valid = 1'b1; mac_data = 64'h1111;
        cache_valid = 1'b1; cache_addr = 48'hABC0;
        dec_valid = 1'b1; dec_addr = 48'hDE00; dec_tag = 2'b10;
        #1;
        check("prio_mac_ready", mac_ready, 1);
        check("prio_cache_wait", cache_ready, 0);
        check("prio_dec_wait", dec_ready, 0);
        next();
        check("n1_no_st", req_mem_st, 0);
        check("n1_no_ld", req_mem_ld, 0);
        mac_valid = 1'b0;
        #1;
        check("prio_cache_ready", cache_ready, 1);
        check("prio_dec_wait2", dec_ready, 0);
        next();
        check("prio_out1_st", req_mem_st, 1);
        check("prio_out1_ld", req_mem_ld, 0);
        check("prio_out1_addr", req_mem_addr, 48'h2000);
        check("prio_out1_data", req_mem_d_or_tag, 64'h1111);
        cache_valid = 1'b0;
        #1 check("prio_dec_ready", dec_ready, 1);
        next();
        check("prio_out2_ld", req_mem_ld, 1);
        check("prio_out2_st", req_mem_st, 0);
        check("prio_out2_addr", req_mem_addr, 48'hABC0);
        check("prio_out2_tag", req_mem_d_or_tag, 64'h1);
        dec_valid = 1'b0;
        next();
        check("prio_out3_ld", req_mem_ld, 1);
        check("prio_out3_addr", req_mem_addr, 48'hDE00);
        check("prio_out3_tag", req_mem_d_or_tag, 64'h4);
        next();
        check("prio_done_ld", req_mem_ld, 0);
        check("prio_done_idle", idle, 1);

        // Base load coinciding with a store: store uses old pointer, pointer takes new base.
        check("st_addr_2008", st_addr, 48'h2008);
        mac_valid = 1'b1; mac_data = 64'h2222; st_base_ld = 1'b1; st_base = 48'h5000;
        #1 check("coinc_mac_ready", mac_ready, 1);
        next();
        mac_valid = 1'b0; st_base_ld = 1'b0;
        check("coinc_st_addr", st_addr, 48'h5000);
        next();
        check("coinc_st", req_mem_st, 1);
        check("coinc_addr", req_mem_addr, 48'h2008);
        check("coinc_data", req_mem_d_or_tag, 64'h2222);
        next();
        check("coinc_idle", idle, 1);

        // Stall for 10 cycles with cache always valid: exactly SKID_DEPTH acceptances.
        req_mem_stall = 1'b1; cache_valid = 1'b1; acc = 0;
        for (int i = 0; i < 10; i++) begin
            cache_addr = 48'h100 + 48'(acc) * 48'h40;
            #1;
            if (cache_ready) acc++;
            check("stall_no_issue", req_mem_ld, 0);
            next();
        end
        check("stall_accepts", 64'(acc), 64'(SKID_DEPTH));
        check("stall_full_ready", cache_ready, 0);
        req_mem_stall = 1'b0; cache_valid = 1'b0; n_got = 0;
        for (int i = 0; i < 10; i++) begin
            next();
            if (req_mem_ld) begin
                if (n_got < 8) got[n_got] = req_mem_addr;
                n_got++;
            end
        end
        check("drain_count", 64'(n_got), 64'd4);
        check("drain_addr0", got[0], 48'h100);
        check("drain_addr1", got[1], 48'h140);
        check("drain_addr2", got[2], 48'h180);
        check("drain_addr3", got[3], 48'h1C0);
        check("drain_idle", idle, 1);

        // Reset with entries queued: outputs clear at once and nothing queued is replayed.
        req_mem_stall = 1'b1; cache_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cache_addr = 48'h900 + 48'(i) * 48'h40;
            #1 check("q_accept", cache_ready, 1);
            next();
        end
        cache_valid = 1'b0; req_mem_stall = 1'b0;
        next();
        next();
        check("q_first_ld", req_mem_ld, 1);
        check("q_first_addr", req_mem_addr, 48'h900);
        cache_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("mid_rst_ld", req_mem_ld, 0);
        check("mid_rst_addr", req_mem_addr, 0);
        check("mid_rst_data", req_mem_d_or_tag, 0);
        check("mid_rst_ready", cache_ready, 0);
        check("mid_rst_st_addr", st_addr, 0);
        cache_valid = 1'b0;
        next();
        rst = 1'b1;
        #1 check("post_rst_idle", idle, 1);
        for (int i = 0; i < 8; i++) begin
            next();
            check("no_replay_ld", req_mem_ld, 0);
            check("no_replay_st", req_mem_st, 0);
        end

        // Constant mac and dec: guard forces a dec grant after every STARVE_LIMIT mac grants.
        st_end = 48'h3000;
        mac_valid = 1'b1; mac_data = 64'h55;
        dec_valid = 1'b1; dec_addr = 48'h7000; dec_tag = 2'b01;
        for (int i = 0; i < 20; i++) begin
            exp_dec = GUARD && ((i % (STARVE_LIMIT + 1)) == STARVE_LIMIT);
            #1;
            check("starve_dec_ready", dec_ready, exp_dec);
            check("starve_mac_ready", mac_ready, !exp_dec);
            next();
        end
        mac_valid = 1'b0; dec_valid = 1'b0;
        next();
        next();
        next();
        check("final_idle", idle, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
